alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered downstream stage for the combinational parameterised ALU (inputs A, B, 3-bit select; outputs result and carry).
- Captures each ALU transaction (operands, select, result, carry) under a valid/ready handshake and derives status flags: zero, negative, carry, signed overflow.
- Presents the transaction to the writeback consumer through a 2-entry skid buffer, giving full throughput with registered outputs.
- Keeps a saturating count of carry events for debug.

Parameters:
- WIDTH, 4, operand/result width; must match the ALU's WIDTH.
- CNT_WIDTH, 8, width of the carry-event counter.
- SEL_ADD, 3'b000, ALU select code for addition.
- SEL_SUB, 3'b001, ALU select code for subtraction.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  upstream transaction valid.
- in_ready  output  1  stage can accept a transaction.
- in_a  input  WIDTH  operand A as presented to the ALU.
- in_b  input  WIDTH  operand B as presented to the ALU.
- in_sel  input  3  ALU select as presented to the ALU.
- alu_out  input  WIDTH  ALU result for in_a/in_b/in_sel.
- carry_out  input  1  ALU carry for the same transaction.
- out_valid  output  1  output transaction valid.
- out_ready  input  1  downstream accepts.
- out_result  output  WIDTH  registered result.
- out_sel  output  3  registered select.
- out_carry  output  1  registered carry flag.
- out_zero  output  1  result == 0.
- out_neg  output  1  result[WIDTH-1].
- out_ovf  output  1  signed overflow (add/sub only).
- clr_count  input  1  synchronous clear of carry_count.
- carry_count  output  CNT_WIDTH  saturating count of accepted transactions with carry_out=1.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Output register and skid register are invalidated.
  - out_valid=0; out_result, out_sel and all flags are 0.
  - carry_count=0.
  - in_ready=1 from the first cycle after reset.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - out_* stay stable while out_valid & !out_ready.
- Flags are computed combinationally from the inputs at capture and stored with the entry; they are never recomputed from registered data:
  - zero = (alu_out == 0).
  - neg = alu_out[MSB].
  - carry = carry_out.
  - ovf for SEL_ADD: (a[MSB]==b[MSB]) & (r[MSB]!=a[MSB]).
  - ovf for SEL_SUB: (a[MSB]!=b[MSB]) & (r[MSB]!=a[MSB]).
  - ovf for any other select: 0.
- Skid buffer:
  - States: EMPTY (no valid entry), ONE (output register valid), TWO (output and skid registers valid).
  - in_ready = !skid_valid, taken directly from a register with no combinational path from out_ready.
  - EMPTY + input: entry loads the output register; next state ONE.
  - ONE + input + output transfer: new entry replaces the output register; state stays ONE.
  - ONE + input + no output transfer: entry goes to the skid register; next state TWO.
  - ONE + output transfer only: next state EMPTY.
  - TWO + output transfer: skid moves to the output register; next state ONE.
  - TWO: no input is possible because in_ready=0.
- Latency: 1 cycle from input transfer to out_valid. Sustained throughput: 1 transaction per cycle when out_ready=1. No reordering and no loss.
- carry_count:
  - Increments on each input transfer with carry_out=1.
  - Saturates at 2^CNT_WIDTH-1 and never wraps.
  - clr_count alone sets it to 0.
  - clr_count together with a counted transfer sets it to 1.
- Reset mid-operation: both buffered entries are discarded and the counter clears. No partial transfer completes on the reset edge.
- in_valid is ignored while in_ready=0. Upstream must hold its transaction until it is accepted.

Decomposition:
- Shared package alu_pkg holds the select-code constants (SEL_ADD, SEL_SUB and the remaining six codes) and a flags struct/typedef {carry, zero, neg, ovf}. The ALU and its testbench use the same package.
- One natural sub-module: alu_skid_buf, a generic 2-entry valid/ready skid buffer parameterised by payload width. Here the payload is {result, sel, flags}.
- Flag derivation and carry_count stay in the top module.

Test Plan:
- Reset, then a single add: a=1011, b=0101, sel=000, alu_out=0000, carry=1.
  - out_valid is asserted 1 cycle later.
  - Required: out_result=0000, zero=1, neg=0, carry=1, ovf=0, carry_count=1.
- Subtract overflow: a=1011, b=0101, sel=001, alu_out=0110, carry=0.
  - Required: ovf=1, neg=0, zero=0.
- Non-arithmetic select: sel=010 with alu_out=1000.
  - Required: ovf=0 regardless of operands, neg=1.
- Backpressure: send 3 back-to-back transactions with out_ready=0.
  - Required: in_ready drops after 2 accepted, the third is held, and outputs stay stable.
  - Then raise out_ready: all 3 emerge in order on consecutive cycles with none lost.
- Counter saturation and clear: with CNT_WIDTH=2, accept 5 carry=1 transactions.
  - Required: count 1,2,3,3,3.
  - Assert clr_count in the same cycle as a carry transfer: required count=1.
- Reset mid-stream: assert rst_n=0 while in state TWO.
  - Required: next cycle out_valid=0, carry_count=0, in_ready=1.
  - Previously buffered entries never appear at the output.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: select codes, status flag bundle, skid buffer states.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOT = 3'b101,
    ALU_SHL = 3'b110,
    ALU_SHR = 3'b111
  } alu_sel_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
  } alu_flags_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream (ALU transaction) and downstream (writeback) handshake bundle.
interface alu_result_stage_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_sel;
  logic [WIDTH-1:0] alu_out;
  logic             carry_out;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_sel;
  logic             out_carry;
  logic             out_zero;
  logic             out_neg;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_sel, alu_out, carry_out, out_ready,
    input  in_ready, out_valid, out_result, out_sel, out_carry, out_zero,
           out_neg, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sel, alu_out, carry_out, out_ready,
    output in_ready, out_valid, out_result, out_sel, out_carry, out_zero,
           out_neg, out_ovf
  );
endinterface

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with registered outputs.
module alu_skid_buf
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  skid_state_e           state, state_next;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  in_fire, out_fire;
  logic                  load_out, load_skid, skid_to_out;

  // Both handshake outputs decode the state register only, so in_ready
  // never depends combinationally on out_ready.
  assign in_ready  = (state != SKID_TWO);
  assign out_valid = (state != SKID_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Next-state and register-load decisions
  always_comb begin
    state_next  = state;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    unique case (state)
      SKID_EMPTY: begin
        if (in_fire) begin
          load_out   = 1'b1;
          state_next = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (in_fire && out_fire) begin
          load_out = 1'b1;
        end else if (in_fire) begin
          load_skid  = 1'b1;
          state_next = SKID_TWO;
        end else if (out_fire) begin
          state_next = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (out_fire) begin
          skid_to_out = 1'b1;
          state_next  = SKID_ONE;
        end
      end
      default: state_next = SKID_EMPTY;
    endcase
  end

  // State and data registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SKID_EMPTY;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      state <= state_next;
      if (load_out) begin
        out_data <= in_data;
      end else if (skid_to_out) begin
        out_data <= skid_data;
      end
      if (load_skid) begin
        skid_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind the ALU: flag derivation, skid buffering,
// saturating carry-event counter.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned CNT_WIDTH = 8,
  parameter logic [2:0]  SEL_ADD   = ALU_ADD,
  parameter logic [2:0]  SEL_SUB   = ALU_SUB
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_result_stage_if.slave    bus,
  input  logic                 clr_count,
  output logic [CNT_WIDTH-1:0] carry_count
);

  localparam int unsigned PAYLOAD_W = WIDTH + 3 + $bits(alu_flags_t);

  alu_flags_t             flags_in, flags_out;
  logic [PAYLOAD_W-1:0]   payload_in, payload_out;
  logic                   msb_a, msb_b, msb_r;
  logic                   count_hit;

  assign msb_a = bus.in_a[WIDTH-1];
  assign msb_b = bus.in_b[WIDTH-1];
  assign msb_r = bus.alu_out[WIDTH-1];

  // Status flags derived from the live ALU transaction at capture time
  always_comb begin
    flags_in       = '0;
    flags_in.carry = bus.carry_out;
    flags_in.zero  = (bus.alu_out == '0);
    flags_in.neg   = msb_r;
    if (bus.in_sel == SEL_ADD) begin
      flags_in.ovf = (msb_a == msb_b) && (msb_r != msb_a);
    end else if (bus.in_sel == SEL_SUB) begin
      flags_in.ovf = (msb_a != msb_b) && (msb_r != msb_a);
    end
  end

  assign payload_in = {bus.alu_out, bus.in_sel, flags_in};

  alu_skid_buf #(
    .DATA_WIDTH(PAYLOAD_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (payload_in),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (payload_out)
  );

  assign {bus.out_result, bus.out_sel, flags_out} = payload_out;
  assign bus.out_carry = flags_out.carry;
  assign bus.out_zero  = flags_out.zero;
  assign bus.out_neg   = flags_out.neg;
  assign bus.out_ovf   = flags_out.ovf;

  assign count_hit = bus.in_valid & bus.in_ready & bus.carry_out;

  // Saturating carry-event counter; a clear coinciding with a counted
  // transfer leaves exactly that one event counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_count <= '0;
    end else if (clr_count) begin
      carry_count <= count_hit ? CNT_WIDTH'(1) : '0;
    end else if (count_hit && (carry_count != '1)) begin
      carry_count <= carry_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage (WIDTH=4, CNT_WIDTH=2).
module tb_alu_result_stage;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_count = 1'b0;
  logic [1:0] carry_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;
  int pops = 0;
  int base_pops;
  bit rand_phase;
  logic [10:0] exp_q[$];
  int sat_exp[5] = '{1, 2, 3, 3, 3};

  alu_result_stage_if #(.WIDTH(4)) bus ();

  alu_result_stage #(
    .WIDTH(4),
    .CNT_WIDTH(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .clr_count   (clr_count),
    .carry_count (carry_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference word {result, sel, carry, zero, neg, ovf}
  function automatic logic [10:0] model(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] sel, input logic [3:0] r,
                                        input logic c);
    logic ovf;
    ovf = 1'b0;
    if (sel == 3'b000) ovf = (a[3] == b[3]) && (r[3] != a[3]);
    if (sel == 3'b001) ovf = (a[3] != b[3]) && (r[3] != a[3]);
    return {r, sel, c, (r == 4'd0), r[3], ovf};
  endfunction

  function automatic logic [10:0] dut_word();
    return {bus.out_result, bus.out_sel, bus.out_carry, bus.out_zero, bus.out_neg, bus.out_ovf};
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                      input logic [3:0] r, input logic c);
    bit done;
    done = 1'b0;
    bus.in_a = a; bus.in_b = b; bus.in_sel = sel; bus.alu_out = r; bus.carry_out = c;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(model(a, b, sel, r, c));
        @(posedge clk);
        #1;
        if (clr_count) exp_count = c ? 1 : 0;
        else if (c && exp_count != 3) exp_count++;
        done = 1'b1;
      end
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  // Output monitor: every valid output must match the scoreboard head
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          check("out", 32'(dut_word()), 32'(exp_q[0]));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
      check("count", 32'(carry_count), 32'(exp_count));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_sel = '0;
    bus.alu_out = '0; bus.carry_out = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_word", 32'(dut_word()), 32'd0);
    check("rst_count", 32'(carry_count), 32'd0);

    // Directed flag cases
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(4'b1011, 4'b0101, 3'b000, 4'b0000, 1'b1);
    @(negedge clk); #1;
    check("add_latency", 32'(bus.out_valid), 32'd1);
    check("add_word", 32'(dut_word()), 32'(11'b0000_000_1100));
    check("add_count", 32'(carry_count), 32'd1);
    @(posedge clk); #1;
    send(4'b1011, 4'b0101, 3'b001, 4'b0110, 1'b0);
    @(negedge clk); #1;
    check("sub_ovf_word", 32'(dut_word()), 32'(11'b0110_001_0001));
    @(posedge clk); #1;
    send(4'b0111, 4'b0111, 3'b010, 4'b1000, 1'b0);
    @(negedge clk); #1;
    check("logic_word", 32'(dut_word()), 32'(11'b1000_010_0010));
    @(posedge clk); #1;

    // Backpressure: two fill the buffer, the third is held
    bus.out_ready = 1'b0;
    send(4'h1, 4'h2, 3'b000, 4'h3, 1'b0);
    send(4'h4, 4'h5, 3'b011, 4'h5, 1'b0);
    fork
      send(4'h6, 4'h7, 3'b100, 4'h1, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("held_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk); #1;
        base_pops = pops;
        bus.out_ready = 1'b1;
      end
    join
    @(negedge clk); #1;
    check("drain_consecutive", 32'(pops - base_pops), 32'd3);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    // Saturation, then clear coinciding with a counted transfer
    @(posedge clk); #1;
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    exp_count = 0;
    for (int i = 0; i < 5; i++) begin
      send(4'(i), 4'hF, 3'b000, 4'(i + 15), 1'b1);
      @(negedge clk); #1;
      check("sat_count", 32'(carry_count), 32'(sat_exp[i]));
      @(posedge clk); #1;
    end
    clr_count = 1'b1;
    send(4'h8, 4'h8, 3'b000, 4'h0, 1'b1);
    clr_count = 1'b0;
    @(negedge clk); #1;
    check("clr_with_carry", 32'(carry_count), 32'd1);

    // Random traffic with random backpressure
    @(posedge clk); #1;
    rand_phase = 1'b1;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          send(4'($urandom), 4'($urandom), 3'($urandom), 4'($urandom), 1'($urandom));
        end
        rand_phase = 1'b0;
      end
      begin
        while (rand_phase) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1 check("rand_drained", 32'(exp_q.size()), 32'd0);

    // Reset while two entries are buffered
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(4'h9, 4'h3, 3'b001, 4'h6, 1'b1);
    send(4'hA, 4'h3, 3'b001, 4'h7, 1'b1);
    @(negedge clk); #1;
    check("two_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    exp_count = 0;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_count", 32'(carry_count), 32'd0);
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    send(4'h2, 4'h2, 3'b000, 4'h4, 1'b0);
    repeat (3) @(negedge clk);
    #1 check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
